// File: rtl/csr_pkg.sv
// Shared definitions for the CSR read-modify-write unit: Zicsr funct3 codes,
// merge operations, FSM states and CSR address field positions.
package csr_pkg;

  localparam logic [2:0] CSR_RW  = 3'b001;
  localparam logic [2:0] CSR_RS  = 3'b010;
  localparam logic [2:0] CSR_RC  = 3'b011;
  localparam logic [2:0] CSR_RWI = 3'b101;
  localparam logic [2:0] CSR_RSI = 3'b110;
  localparam logic [2:0] CSR_RCI = 3'b111;

  // The low two funct3 bits select the merge; bit 2 only selects the operand source.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MODIFY,
    ST_WRITE,
    ST_RESP
  } csr_state_e;

  localparam int CSR_RO_MSB   = 11;
  localparam int CSR_RO_LSB   = 10;
  localparam int CSR_PRIV_MSB = 9;
  localparam int CSR_PRIV_LSB = 8;

  function automatic logic is_legal_funct3(input logic [2:0] f3);
    case (f3)
      CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_rmw_merge.sv
// Combinational merge: applies the RW/RS/RC operation to the old CSR value and
// keeps every bit outside the WARL writable mask unchanged.
module csr_rmw_merge
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_operand,
  input  logic [XLEN-1:0] i_mask,
  output logic [XLEN-1:0] o_wdata
);

  logic [XLEN-1:0] w_new;

  always_comb begin
    w_new = i_operand;
    case (csr_op_e'(i_op))
      OP_RS:   w_new = i_old | i_operand;
      OP_RC:   w_new = i_old & ~i_operand;
      default: w_new = i_operand;
    endcase
  end

  assign o_wdata = (i_old & ~i_mask) | (w_new & i_mask);

endmodule

// File: rtl/csr_rmw_unit.sv
// Sequential Zicsr read-modify-write engine between execute and the CSR file:
// read, merge under the WARL mask, write back, then return the old value.
module csr_rmw_unit
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12,
  parameter int PRIV_W = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [2:0]        funct3_in,
  input  logic [ADDR_W-1:0] csr_addr_in,
  input  logic [XLEN-1:0]   rs1_data_in,
  input  logic [4:0]        rs1_idx_uimm_in,
  input  logic [4:0]        rd_idx_in,
  input  logic [PRIV_W-1:0] priv_in,
  input  logic              flush_in,
  output logic              csr_rd_en_out,
  output logic [ADDR_W-1:0] csr_addr_out,
  input  logic [XLEN-1:0]   csr_rdata_in,
  input  logic [XLEN-1:0]   csr_wmask_in,
  output logic              csr_wr_en_out,
  output logic [XLEN-1:0]   csr_wdata_out,
  output logic              resp_valid_out,
  input  logic              resp_ready_in,
  output logic [XLEN-1:0]   rd_data_out,
  output logic              illegal_out
);

  csr_state_e        r_state;
  csr_state_e        w_next;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_operand;
  logic [XLEN-1:0]   r_old;
  logic [XLEN-1:0]   r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_no_read;
  logic              r_no_write;
  logic              r_illegal;

  logic              w_accept;
  logic [XLEN-1:0]   w_operand;
  logic              w_no_read;
  logic              w_no_write;
  logic [PRIV_W-1:0] w_priv_need;
  logic              w_illegal;
  logic [XLEN-1:0]   w_old;
  logic [XLEN-1:0]   w_wdata;

  assign w_accept    = (r_state == ST_IDLE) && req_valid_in;
  assign w_operand   = funct3_in[2] ? XLEN'(rs1_idx_uimm_in) : rs1_data_in;
  assign w_no_read   = (funct3_in[1:0] == OP_RW) && (rd_idx_in == 5'd0);
  assign w_no_write  = (funct3_in[1:0] != OP_RW) && (rs1_idx_uimm_in == 5'd0);
  assign w_priv_need = PRIV_W'(csr_addr_in[CSR_PRIV_MSB:CSR_PRIV_LSB]);

  // A read-only CSR stays legal as long as the instruction is a pure read.
  assign w_illegal = !is_legal_funct3(funct3_in)
                   || (w_priv_need > priv_in)
                   || ((csr_addr_in[CSR_RO_MSB:CSR_RO_LSB] == 2'b11) && !w_no_write);

  assign w_old = r_no_read ? '0 : csr_rdata_in;

  csr_rmw_merge #(
    .XLEN (XLEN)
  ) u_merge (
    .i_op      (r_op),
    .i_old     (w_old),
    .i_operand (r_operand),
    .i_mask    (csr_wmask_in),
    .o_wdata   (w_wdata)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_operand  <= '0;
      r_old      <= '0;
      r_wdata    <= '0;
      r_addr     <= '0;
      r_no_read  <= 1'b0;
      r_no_write <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op       <= funct3_in[1:0];
        r_operand  <= w_operand;
        r_no_read  <= w_no_read;
        r_no_write <= w_no_write;
        r_illegal  <= w_illegal;
        r_old      <= '0;
        if (!w_illegal) begin
          r_addr <= csr_addr_in;
        end
      end
      if (r_state == ST_MODIFY) begin
        r_old   <= w_old;
        r_wdata <= w_wdata;
      end
    end
  end

  // Flush only matters before the write; WRITE and RESP are past the commit point.
  always_comb begin
    w_next         = r_state;
    req_ready_out  = 1'b0;
    csr_rd_en_out  = 1'b0;
    csr_wr_en_out  = 1'b0;
    resp_valid_out = 1'b0;
    rd_data_out    = '0;
    illegal_out    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) begin
          w_next = w_illegal ? ST_RESP : ST_READ;
        end
      end
      ST_READ: begin
        csr_rd_en_out = !r_no_read;
        w_next        = flush_in ? ST_IDLE : ST_MODIFY;
      end
      ST_MODIFY: begin
        w_next = flush_in ? ST_IDLE : ST_WRITE;
      end
      ST_WRITE: begin
        csr_wr_en_out = !r_no_write;
        w_next        = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_out = 1'b1;
        rd_data_out    = r_old;
        illegal_out    = r_illegal;
        if (resp_ready_in) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign csr_addr_out  = r_addr;
  assign csr_wdata_out = r_wdata;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Directed bench for csr_rmw_unit: a transaction-level model predicts each op,
// and a per-cycle compare process checks the DUT's strobes and response.
module tb_csr_rmw_unit;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [2:0]  funct3_in;
  logic [11:0] csr_addr_in;
  logic [31:0] rs1_data_in;
  logic [4:0]  rs1_idx_uimm_in;
  logic [4:0]  rd_idx_in;
  logic [1:0]  priv_in;
  logic        flush_in;
  logic        csr_rd_en_out;
  logic [11:0] csr_addr_out;
  logic [31:0] csr_rdata_in;
  logic [31:0] csr_wmask_in;
  logic        csr_wr_en_out;
  logic [31:0] csr_wdata_out;
  logic        resp_valid_out;
  logic        resp_ready_in;
  logic [31:0] rd_data_out;
  logic        illegal_out;

  csr_rmw_unit #(
    .XLEN   (32),
    .ADDR_W (12),
    .PRIV_W (2)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .funct3_in       (funct3_in),
    .csr_addr_in     (csr_addr_in),
    .rs1_data_in     (rs1_data_in),
    .rs1_idx_uimm_in (rs1_idx_uimm_in),
    .rd_idx_in       (rd_idx_in),
    .priv_in         (priv_in),
    .flush_in        (flush_in),
    .csr_rd_en_out   (csr_rd_en_out),
    .csr_addr_out    (csr_addr_out),
    .csr_rdata_in    (csr_rdata_in),
    .csr_wmask_in    (csr_wmask_in),
    .csr_wr_en_out   (csr_wr_en_out),
    .csr_wdata_out   (csr_wdata_out),
    .resp_valid_out  (resp_valid_out),
    .resp_ready_in   (resp_ready_in),
    .rd_data_out     (rd_data_out),
    .illegal_out     (illegal_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        illegal;
    logic        doRead;
    logic        doWrite;
    logic [31:0] wdata;
    logic [31:0] rdData;
  } expect_t;

  int testsRun = 0;
  int testsFailed = 0;

  logic        checkEn = 1'b0;
  logic        expReady, expRdEn, expAddrChk, expWrEn, expResp, expIllegal;
  logic [11:0] expAddr;
  logic [31:0] expWdata, expRdData;

  int          rdCount = 0, wrCount = 0, respCount = 0;
  int          rdBase, wrBase, respBase;
  logic [31:0] seenWdata = '0, seenRdData = '0;
  logic        seenIllegal = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-instruction view of Zicsr semantics, independent of any cycle schedule.
  function automatic expect_t modelOp(input logic [2:0] f3, input logic [11:0] addr,
                                      input logic [31:0] rs1, input logic [4:0] idx,
                                      input logic [4:0] rd, input logic [1:0] priv,
                                      input logic [31:0] oldVal, input logic [31:0] maskVal);
    expect_t     e;
    logic [31:0] opnd, oldSeen, newVal;
    logic        writesOnly, noWrite, legalF3;
    e          = '0;
    oldSeen    = 32'd0;
    newVal     = 32'd0;
    opnd       = f3[2] ? {27'd0, idx} : rs1;
    writesOnly = (f3 == 3'b001) || (f3 == 3'b101);
    legalF3    = (f3 != 3'b000) && (f3 != 3'b100);
    noWrite    = !writesOnly && (idx == 5'd0);
    e.illegal  = !legalF3 || (addr[9:8] > priv) || ((addr[11:10] == 2'b11) && !noWrite);
    if (!e.illegal) begin
      e.doRead  = !(writesOnly && (rd == 5'd0));
      e.doWrite = !noWrite;
      oldSeen   = e.doRead ? oldVal : 32'd0;
      case (f3[1:0])
        2'b01:   newVal = opnd;
        2'b10:   newVal = oldSeen | opnd;
        default: newVal = oldSeen & ~opnd;
      endcase
      e.wdata  = (oldSeen & ~maskVal) | (newVal & maskVal);
      e.rdData = oldSeen;
    end
    return e;
  endfunction

  initial forever begin
    @(negedge clk_in);
    if (checkEn) begin
      checkOutput("req_ready", 32'(req_ready_out), 32'(expReady));
      checkOutput("csr_rd_en", 32'(csr_rd_en_out), 32'(expRdEn));
      checkOutput("csr_wr_en", 32'(csr_wr_en_out), 32'(expWrEn));
      checkOutput("resp_valid", 32'(resp_valid_out), 32'(expResp));
      if (expAddrChk) checkOutput("csr_addr", 32'(csr_addr_out), 32'(expAddr));
      if (expWrEn) checkOutput("csr_wdata", csr_wdata_out, expWdata);
      if (expResp) begin
        checkOutput("rd_data", rd_data_out, expRdData);
        checkOutput("illegal", 32'(illegal_out), 32'(expIllegal));
      end
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (csr_rd_en_out) rdCount++;
    if (csr_wr_en_out) begin
      wrCount++;
      seenWdata = csr_wdata_out;
    end
    if (resp_valid_out) begin
      respCount++;
      seenRdData  = rd_data_out;
      seenIllegal = illegal_out;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic setExp(input logic ready, input logic rdEn, input logic addrChk,
                        input logic wrEn, input logic resp);
    expReady   = ready;
    expRdEn    = rdEn;
    expAddrChk = addrChk;
    expWrEn    = wrEn;
    expResp    = resp;
  endtask

  task automatic finishIdle();
    setExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
  endtask

  // flushCycle: 0 IDLE, 1 READ, 2 MODIFY, 3 WRITE, 4 first RESP cycle, -1 none.
  task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] addr,
                               input logic [31:0] rs1, input logic [4:0] idx,
                               input logic [4:0] rd, input logic [1:0] priv,
                               input logic [31:0] oldVal, input logic [31:0] maskVal,
                               input int flushCycle, input int respDelay);
    expect_t e;
    e          = modelOp(f3, addr, rs1, idx, rd, priv, oldVal, maskVal);
    expAddr    = addr;
    expWdata   = e.wdata;
    expRdData  = e.rdData;
    expIllegal = e.illegal;
    rdBase     = rdCount;
    wrBase     = wrCount;
    respBase   = respCount;

    req_valid_in    = 1'b1;
    funct3_in       = f3;
    csr_addr_in     = addr;
    rs1_data_in     = rs1;
    rs1_idx_uimm_in = idx;
    rd_idx_in       = rd;
    priv_in         = priv;
    flush_in        = (flushCycle == 0);
    setExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    req_valid_in    = 1'b0;
    flush_in        = 1'b0;
    funct3_in       = ~f3;
    csr_addr_in     = ~addr;
    rs1_data_in     = ~rs1;
    rs1_idx_uimm_in = ~idx;
    rd_idx_in       = ~rd;
    priv_in         = ~priv;

    if (!e.illegal) begin
      setExp(1'b0, e.doRead, 1'b1, 1'b0, 1'b0);
      flush_in = (flushCycle == 1);
      nextCycle();
      flush_in = 1'b0;
      if (flushCycle == 1) begin
        finishIdle();
        return;
      end
      setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      csr_rdata_in = oldVal;
      csr_wmask_in = maskVal;
      flush_in     = (flushCycle == 2);
      nextCycle();
      flush_in     = 1'b0;
      csr_rdata_in = 32'hA5A5A5A5;
      csr_wmask_in = 32'h5A5A5A5A;
      if (flushCycle == 2) begin
        finishIdle();
        return;
      end
      setExp(1'b0, 1'b0, 1'b1, e.doWrite, 1'b0);
      flush_in = (flushCycle == 3);
      nextCycle();
      flush_in = 1'b0;
    end

    for (int k = 0; k <= respDelay; k++) begin
      setExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      resp_ready_in = (k == respDelay);
      flush_in      = (k == 0) && (flushCycle == 4);
      nextCycle();
      flush_in      = 1'b0;
    end
    resp_ready_in = 1'b0;
    finishIdle();
  endtask

  task automatic checkCounts(input string tag, input int rdN, input int wrN, input int respN);
    checkOutput({tag, "_reads"}, 32'(rdCount - rdBase), 32'(rdN));
    checkOutput({tag, "_writes"}, 32'(wrCount - wrBase), 32'(wrN));
    checkOutput({tag, "_resps"}, 32'(respCount - respBase), 32'(respN));
  endtask

  task automatic resetInRead();
    req_valid_in    = 1'b1;
    funct3_in       = 3'b001;
    csr_addr_in     = 12'h340;
    rs1_data_in     = 32'h11112222;
    rs1_idx_uimm_in = 5'd1;
    rd_idx_in       = 5'd1;
    priv_in         = 2'd3;
    flush_in        = 1'b0;
    expAddr         = 12'h340;
    setExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    req_valid_in = 1'b0;
    setExp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    checkOutput("rst_pre_rdEn", 32'(csr_rd_en_out), 32'd1);
    rst_n_in = 1'b0;
    setExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("rst_ready", 32'(req_ready_out), 32'd1);
    checkOutput("rst_rdEn", 32'(csr_rd_en_out), 32'd0);
    checkOutput("rst_addr", 32'(csr_addr_out), 32'd0);
    checkOutput("rst_wdata", csr_wdata_out, 32'd0);
    checkOutput("rst_rdData", rd_data_out, 32'd0);
    nextCycle();
    rst_n_in = 1'b1;
    finishIdle();
  endtask

  initial begin
    rst_n_in        = 1'b0;
    req_valid_in    = 1'b0;
    funct3_in       = 3'b000;
    csr_addr_in     = 12'h000;
    rs1_data_in     = 32'd0;
    rs1_idx_uimm_in = 5'd0;
    rd_idx_in       = 5'd0;
    priv_in         = 2'd0;
    flush_in        = 1'b0;
    csr_rdata_in    = 32'hA5A5A5A5;
    csr_wmask_in    = 32'h5A5A5A5A;
    resp_ready_in   = 1'b0;

    @(negedge clk_in);
    checkOutput("reset_ready", 32'(req_ready_out), 32'd1);
    checkOutput("reset_rdEn", 32'(csr_rd_en_out), 32'd0);
    checkOutput("reset_wrEn", 32'(csr_wr_en_out), 32'd0);
    checkOutput("reset_resp", 32'(resp_valid_out), 32'd0);
    checkOutput("reset_rdData", rd_data_out, 32'd0);
    checkOutput("reset_illegal", 32'(illegal_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    setExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkEn = 1'b1;
    nextCycle();

    checkOutput("model_rs", 32'(modelOp(3'b010, 12'h340, 32'h0000F000, 5'd2, 5'd6, 2'd3,
                32'h000000FF, 32'h0000FFF0).wdata), 32'h0000F0FF);
    checkOutput("model_rci", 32'(modelOp(3'b111, 12'h340, 32'd0, 5'h1F, 5'd7, 2'd3,
                32'hFFFFFFFF, 32'hFFFFFFFF).wdata), 32'hFFFFFFE0);
    checkOutput("model_ro_rw", 32'(modelOp(3'b001, 12'hC00, 32'd1, 5'd1, 5'd3, 2'd3,
                32'd0, 32'hFFFFFFFF).illegal), 32'd1);

    applyStimulus(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 5'd5, 2'd3, 32'h12345678, 32'hFFFFFFFF, -1, 0);
    checkCounts("rw", 1, 1, 1);
    checkOutput("rw_wdata", seenWdata, 32'hDEADBEEF);
    checkOutput("rw_rdData", seenRdData, 32'h12345678);

    applyStimulus(3'b010, 12'h340, 32'h0000F000, 5'd2, 5'd6, 2'd3, 32'h000000FF, 32'h0000FFF0, -1, 0);
    checkOutput("rs_wdata", seenWdata, 32'h0000F0FF);

    applyStimulus(3'b010, 12'h340, 32'h0000F000, 5'd0, 5'd6, 2'd3, 32'h000000FF, 32'h0000FFF0, -1, 0);
    checkCounts("rs_x0", 1, 0, 1);
    checkOutput("rs_x0_rdData", seenRdData, 32'h000000FF);

    applyStimulus(3'b111, 12'h340, 32'd0, 5'h1F, 5'd7, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0);
    checkOutput("rci_wdata", seenWdata, 32'hFFFFFFE0);

    applyStimulus(3'b101, 12'h340, 32'd0, 5'h0A, 5'd0, 2'd3, 32'h00000055, 32'hFFFFFFFF, -1, 0);
    checkCounts("rwi_rd0", 0, 1, 1);
    checkOutput("rwi_rd0_wdata", seenWdata, 32'h0000000A);
    checkOutput("rwi_rd0_rdData", seenRdData, 32'd0);

    applyStimulus(3'b011, 12'h340, 32'h0F0F0000, 5'd4, 5'd8, 2'd3, 32'hFFFF0000, 32'hFFFFFFFF, -1, 0);
    checkOutput("rc_wdata", seenWdata, 32'hF0F00000);

    applyStimulus(3'b001, 12'h340, 32'hFFFFFFFF, 5'd9, 5'd1, 2'd3, 32'h00000000, 32'h000000F0, -1, 0);
    checkOutput("rw_masked_wdata", seenWdata, 32'h000000F0);

    applyStimulus(3'b010, 12'hC00, 32'd0, 5'd0, 5'd3, 2'd0, 32'hCAFE0001, 32'hFFFFFFFF, -1, 0);
    checkCounts("ro_read", 1, 0, 1);
    checkOutput("ro_read_rdData", seenRdData, 32'hCAFE0001);

    applyStimulus(3'b001, 12'hC00, 32'd1, 5'd1, 5'd3, 2'd3, 32'h12345678, 32'hFFFFFFFF, -1, 0);
    checkCounts("ro_write", 0, 0, 1);
    checkOutput("ro_write_illegal", 32'(seenIllegal), 32'd1);

    applyStimulus(3'b010, 12'h300, 32'h8, 5'd1, 5'd3, 2'd0, 32'h12345678, 32'hFFFFFFFF, -1, 0);
    checkCounts("priv", 0, 0, 1);
    checkOutput("priv_illegal", 32'(seenIllegal), 32'd1);

    applyStimulus(3'b000, 12'h340, 32'h8, 5'd1, 5'd3, 2'd3, 32'h12345678, 32'hFFFFFFFF, -1, 0);
    applyStimulus(3'b100, 12'h340, 32'h8, 5'd1, 5'd3, 2'd3, 32'h12345678, 32'hFFFFFFFF, -1, 0);
    checkOutput("f3_100_illegal", 32'(seenIllegal), 32'd1);

    applyStimulus(3'b001, 12'h341, 32'h00000777, 5'd1, 5'd2, 2'd3, 32'h00000111, 32'hFFFFFFFF, 0, 0);
    checkCounts("flush_idle", 1, 1, 1);

    applyStimulus(3'b001, 12'h342, 32'h00000777, 5'd1, 5'd2, 2'd3, 32'h00000111, 32'hFFFFFFFF, 1, 0);
    checkCounts("flush_read", 1, 0, 0);

    applyStimulus(3'b010, 12'h343, 32'h00000777, 5'd1, 5'd2, 2'd3, 32'h00000111, 32'hFFFFFFFF, 2, 0);
    checkCounts("flush_modify", 1, 0, 0);

    applyStimulus(3'b010, 12'h344, 32'h00000700, 5'd1, 5'd2, 2'd3, 32'h00000011, 32'hFFFFFFFF, 3, 0);
    checkCounts("flush_write", 1, 1, 1);
    checkOutput("flush_write_wdata", seenWdata, 32'h00000711);

    applyStimulus(3'b110, 12'h345, 32'd0, 5'h03, 5'd2, 2'd3, 32'h00000010, 32'hFFFFFFFF, 4, 0);
    checkCounts("flush_resp", 1, 1, 1);

    applyStimulus(3'b010, 12'h340, 32'h00000100, 5'd1, 5'd2, 2'd3, 32'h0000ABCD, 32'hFFFFFFFF, -1, 3);
    checkCounts("resp_hold", 1, 1, 4);
    checkOutput("resp_hold_rdData", seenRdData, 32'h0000ABCD);

    resetInRead();
    applyStimulus(3'b001, 12'h340, 32'h00C0FFEE, 5'd1, 5'd5, 2'd3, 32'h00000042, 32'hFFFFFFFF, -1, 0);
    checkCounts("post_reset", 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
